// File: rtl/operand_fetch.sv
// Register file with a one-cycle registered operand fetch and same-edge write bypass.
// When HOLD is high the operand pair is frozen and ISSUE is dropped; register writes still commit.
module operand_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    input  logic                  ISSUE,
    input  logic                  HOLD,
    output logic [DATA_WIDTH-1:0] DATA1,
    output logic [DATA_WIDTH-1:0] DATA2,
    output logic                  OPVALID
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] op1_nxt;
    logic [DATA_WIDTH-1:0] op2_nxt;

    // A write landing on the same edge as the fetch is forwarded so the operand is never stale.
    always_comb begin
        op1_nxt = regs[OUT1ADDRESS];
        op2_nxt = regs[OUT2ADDRESS];
        if (WRITE && (INADDRESS == OUT1ADDRESS)) op1_nxt = IN;
        if (WRITE && (INADDRESS == OUT2ADDRESS)) op2_nxt = IN;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            DATA1   <= '0;
            DATA2   <= '0;
            OPVALID <= 1'b0;
        end else begin
            if (WRITE) regs[INADDRESS] <= IN;
            if (!HOLD) begin
                OPVALID <= ISSUE;
                if (ISSUE) begin
                    DATA1 <= op1_nxt;
                    DATA2 <= op2_nxt;
                end
            end
        end
    end

endmodule
